// File: rtl/gate_pkg.sv
// Shared types and 700 Hz default timings for the parking barrier arbiter.
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CODE,
        OPEN_IN,
        OPEN_OUT,
        ERROR
    } gate_state_t;

    typedef enum logic {
        LANE_IN,
        LANE_OUT
    } lane_t;

    localparam int DEF_CAPACITY   = 16;
    localparam int DEF_CNT_W      = 5;
    localparam int DEF_OPEN_TICKS = 14000;  // 20 s
    localparam int DEF_CODE_TICKS = 7000;   // 10 s
    localparam int DEF_ERR_TICKS  = 2100;   // 3 s
    localparam int DEF_TMR_W      = 14;

endpackage

// File: rtl/gate_arbiter_if.sv
// Sensor/verifier inputs and barrier/indicator outputs of the gate arbiter.
interface gate_arbiter_if #(
    parameter int CNT_W = 5
);
    logic             entry_req;
    logic             exit_req;
    logic             code_ok;
    logic             code_err;
    logic             car_passed;
    logic             gate_open;
    logic             stop;
    logic             code_error;
    logic             full;
    logic             grant_in;
    logic             grant_out;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output entry_req, exit_req, code_ok, code_err, car_passed,
        input  gate_open, stop, code_error, full, grant_in, grant_out, occupancy
    );

    modport slave (
        input  entry_req, exit_req, code_ok, code_err, car_passed,
        output gate_open, stop, code_error, full, grant_in, grant_out, occupancy
    );
endinterface

// File: rtl/gate_timer.sv
// Loadable down-counter that parks at zero; zero flag drives state timeouts.
module gate_timer #(
    parameter int TMR_W = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);
    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - TMR_W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/gate_arbiter.sv
// Shared barrier sequencer: round-robin lane grant, code/open/error windows,
// and the occupancy counter with its full flag.
module gate_arbiter
    import gate_pkg::*;
#(
    parameter int CAPACITY   = DEF_CAPACITY,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int OPEN_TICKS = DEF_OPEN_TICKS,
    parameter int CODE_TICKS = DEF_CODE_TICKS,
    parameter int ERR_TICKS  = DEF_ERR_TICKS,
    parameter int TMR_W      = DEF_TMR_W
) (
    input logic           clock,
    input logic           reset,
    gate_arbiter_if.slave bus
);
    localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_TICKS - 1);
    localparam logic [TMR_W-1:0] CODE_LD = TMR_W'(CODE_TICKS - 1);
    localparam logic [TMR_W-1:0] ERR_LD  = TMR_W'(ERR_TICKS - 1);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);

    gate_state_t      state, nxt;
    lane_t            last_grant, nxt_last;
    logic [CNT_W-1:0] occ, nxt_occ;
    logic             tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             elig_in, elig_out;
    logic             gate_open_q, stop_q, code_error_q, grant_in_q, grant_out_q, full_q;

    gate_timer #(.TMR_W(TMR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign elig_in  = bus.entry_req & ~full_q;
    assign elig_out = bus.exit_req;

    always_comb begin
        nxt      = state;
        nxt_last = last_grant;
        nxt_occ  = occ;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                // Entry wins alone, or on a tie when exit was served last.
                if (elig_in && (!elig_out || last_grant == LANE_OUT)) begin
                    nxt      = WAIT_CODE;
                    nxt_last = LANE_IN;
                    tmr_load = 1'b1;
                    tmr_val  = CODE_LD;
                end else if (elig_out) begin
                    nxt      = OPEN_OUT;
                    nxt_last = LANE_OUT;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LD;
                end
            end
            WAIT_CODE: begin
                if (bus.code_err) begin
                    nxt      = ERROR;
                    tmr_load = 1'b1;
                    tmr_val  = ERR_LD;
                end else if (bus.code_ok) begin
                    nxt      = OPEN_IN;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LD;
                end else if (tmr_zero) begin
                    nxt = IDLE;
                end
            end
            OPEN_IN: begin
                if (bus.car_passed) begin
                    nxt = IDLE;
                    if (occ != CAP)
                        nxt_occ = occ + CNT_W'(1);
                end else if (tmr_zero) begin
                    nxt = IDLE;
                end
            end
            OPEN_OUT: begin
                // An exit at zero occupancy is still served, just not counted.
                if (bus.car_passed) begin
                    nxt = IDLE;
                    if (occ != '0)
                        nxt_occ = occ - CNT_W'(1);
                end else if (tmr_zero) begin
                    nxt = IDLE;
                end
            end
            ERROR: begin
                if (tmr_zero)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= LANE_OUT;
            occ          <= '0;
            full_q       <= (CAPACITY == 0);
            gate_open_q  <= 1'b0;
            stop_q       <= 1'b0;
            code_error_q <= 1'b0;
            grant_in_q   <= 1'b0;
            grant_out_q  <= 1'b0;
        end else begin
            state        <= nxt;
            last_grant   <= nxt_last;
            occ          <= nxt_occ;
            // Follows the registered count, so it trails a pass by one cycle.
            full_q       <= (occ == CAP);
            gate_open_q  <= (nxt == OPEN_IN) || (nxt == OPEN_OUT);
            stop_q       <= (nxt == WAIT_CODE) || (nxt == ERROR);
            code_error_q <= (nxt == ERROR);
            grant_in_q   <= (nxt == WAIT_CODE) || (nxt == OPEN_IN) || (nxt == ERROR);
            grant_out_q  <= (nxt == OPEN_OUT);
        end
    end

    assign bus.gate_open  = gate_open_q;
    assign bus.stop       = stop_q;
    assign bus.code_error = code_error_q;
    assign bus.grant_in   = grant_in_q;
    assign bus.grant_out  = grant_out_q;
    assign bus.full       = full_q;
    assign bus.occupancy  = occ;
endmodule
